// File: rtl/mips_multicycle_core.sv
// ---------------------------------------------------------------------------
// mips_multicycle_core
//
// Multi-cycle MIPS-subset CPU core. One FSM drives a single shared ALU and
// a single unified instruction/data memory port. Every access on that port
// is a request held stable until the memory answers with mem_ready.
//
// Supported instructions: add, sub, and, or, slt, nop (R-type), j, beq,
// addi, lw and sw. Any other opcode or funct, or a misaligned lw/sw, parks
// the core in HALT with the sticky illegal flag set. Only reset leaves HALT.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   mem_req     memory access request (FETCH and MEM states only)
//   mem_we      1 = write (sw), 0 = read
//   mem_addr    byte address, always word aligned
//   mem_wdata   store data (sw only, otherwise 0)
//   mem_rdata   read data, sampled when mem_ready = 1
//   mem_ready   the current access completes this cycle
//   pc          address of the next instruction to fetch
//   state       FSM state code, for debug
//   instr_done  1-cycle pulse in the cycle an instruction retires
//   illegal     sticky flag: illegal op/funct or misaligned access
// ---------------------------------------------------------------------------
module mips_multicycle_core #(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              instr_done,
    output logic              illegal
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_NOP = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       alu_q, alu_d;
    logic [31:0]       mdr_q, mdr_d;
    logic              illegal_q, illegal_d;
    logic [31:0]       regs_q [32];

    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;
    logic              retire;

    // Instruction fields, always taken from the latched IR.
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] eff_addr;
    logic [27:0] jump_target;

    assign opcode      = ir_q[31:26];
    assign rs          = ir_q[25:21];
    assign rt          = ir_q[20:16];
    assign rd          = ir_q[15:11];
    assign funct       = ir_q[5:0];
    assign imm_sext    = {{16{ir_q[15]}}, ir_q[15:0]};
    assign eff_addr    = a_q + imm_sext;
    assign jump_target = {ir_q[25:0], 2'b00};

    function automatic logic opcode_legal(input logic [5:0] op);
        case (op)
            OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: opcode_legal = 1'b1;
            default:                                   opcode_legal = 1'b0;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Next-state and datapath control
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case statements can leave one unassigned and infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        illegal_d = illegal_q;
        rf_we     = 1'b0;
        rf_waddr  = 5'd0;
        rf_wdata  = 32'd0;
        retire    = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                a_d   = regs_q[rs];
                b_d   = regs_q[rt];
                // Branch target precomputed while the ALU is otherwise idle;
                // pc already points past this instruction.
                alu_d = 32'(pc_q) + (imm_sext << 2);
                if (opcode_legal(opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end

            S_EXEC: begin
                case (opcode)
                    OP_R: begin
                        state_d = S_WB;
                        case (funct)
                            FN_ADD: alu_d = a_q + b_q;
                            FN_SUB: alu_d = a_q - b_q;
                            FN_AND: alu_d = a_q & b_q;
                            FN_OR:  alu_d = a_q | b_q;
                            FN_SLT: alu_d = {31'd0, $signed(a_q) < $signed(b_q)};
                            FN_NOP: begin
                                retire  = 1'b1;
                                state_d = S_FETCH;
                            end
                            default: begin
                                state_d   = S_HALT;
                                illegal_d = 1'b1;
                            end
                        endcase
                    end
                    OP_ADDI: begin
                        alu_d   = eff_addr;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_d = eff_addr;
                        // A misaligned address never reaches the bus.
                        if (eff_addr[1:0] != 2'b00) begin
                            state_d   = S_HALT;
                            illegal_d = 1'b1;
                        end else begin
                            state_d = S_MEM;
                        end
                    end
                    OP_BEQ: begin
                        if (a_q == b_q) begin
                            pc_d = alu_q[ADDR_W-1:0];
                        end
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_J: begin
                        pc_d    = jump_target[ADDR_W-1:0];
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end

            S_MEM: begin
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                rf_we = 1'b1;
                case (opcode)
                    OP_R: begin
                        rf_waddr = rd;
                        rf_wdata = alu_q;
                    end
                    OP_ADDI: begin
                        rf_waddr = rt;
                        rf_wdata = alu_q;
                    end
                    default: begin
                        rf_waddr = rt;
                        rf_wdata = mdr_q;
                    end
                endcase
                retire  = 1'b1;
                state_d = S_FETCH;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d   = S_HALT;
                illegal_d = 1'b1;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= PC_RESET;
            ir_q      <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            alu_q     <= 32'd0;
            mdr_q     <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            illegal_q <= illegal_d;
        end
    end

    // Register file. r0 is never written, so it always reads as zero.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the register file is architecturally cleared on reset, so it
        // is built from resettable flops rather than an inferred RAM.
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. The bus outputs are gated by reset so an in-flight access is
    // dropped in the same cycle reset is asserted, not at the next edge.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc_q;
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    mem_addr = alu_q[ADDR_W-1:0];
                    if (opcode == OP_SW) begin
                        mem_we    = 1'b1;
                        mem_wdata = b_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instr_done = retire & ~reset;
    assign pc         = pc_q;
    assign state      = state_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_core
//
// Directed bench for mips_multicycle_core. A small memory model answers the
// unified bus: instruction words come from imem (loaded by the test tasks),
// stored words land in dmem and shadow imem for later reads. Register
// values are observed by storing them and checking the bus write.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_core;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready = 1'b1;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        state;
    logic              instr_done;
    logic              illegal;

    int checks = 0;
    int errors = 0;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    logic        dvalid [64];
    int          wcount;
    logic [7:0]  last_waddr;
    logic [31:0] last_wdata;

    always #5 clk = ~clk;

    mips_multicycle_core #(
        .ADDR_W   (ADDR_W),
        .PC_RESET (8'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .pc         (pc),
        .state      (state),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    assign mem_rdata = dvalid[mem_addr[7:2]] ? dmem[mem_addr[7:2]] : imem[mem_addr[7:2]];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wcount     <= 0;
            last_waddr <= 8'd0;
            last_wdata <= 32'd0;
            for (int i = 0; i < 64; i++) dvalid[i] <= 1'b0;
        end else if (mem_req && mem_we && mem_ready) begin
            dmem[mem_addr[7:2]]   <= mem_wdata;
            dvalid[mem_addr[7:2]] <= 1'b1;
            wcount                <= wcount + 1;
            last_waddr            <= mem_addr;
            last_wdata            <= mem_wdata;
        end
    end

    // ---------------- encoders and sequencing helpers ----------------
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    localparam logic [31:0] BAD_OP = 32'hFC00_0000;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic hold_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 64; i++) imem[i] = 32'd0;
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    // Runs one instruction from its FETCH cycle; cyc counts cycles up to and
    // including the retiring one, leaving the bench in the next FETCH cycle.
    task automatic run_instr(input string name, output int cyc);
        bit seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 40) begin
            cyc++;
            seen = (instr_done === 1'b1);
            step();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: no instr_done within %0d cycles", name, cyc);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        hold_reset();
        #1;
        checks++;
        if ({mem_req, mem_we, instr_done, illegal} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {mem_req, mem_we, instr_done, illegal});
        end
        checks++;
        if ({state, pc, mem_addr, mem_wdata} !== 51'd0) begin
            errors++;
            $display("FAIL reset_values: state %0d pc %h addr %h wdata %h expected all 0",
                     state, pc, mem_addr, mem_wdata);
        end
        release_reset();
        checks++;
        if ({mem_req, mem_we, mem_addr} !== {2'b10, 8'h00}) begin
            errors++;
            $display("FAIL first_fetch: req %b we %b addr %h expected 1 0 00", mem_req, mem_we, mem_addr);
        end
    endtask

    task automatic test_alu();
        int c, total;
        hold_reset();
        imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        imem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        imem[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);
        imem[4] = enc_i(6'h23, 5'd0, 5'd4, 16'd8);
        imem[5] = enc_i(6'h2B, 5'd0, 5'd4, 16'd12);
        imem[6] = BAD_OP;
        release_reset();
        total = 0;
        for (int i = 0; i < 3; i++) begin
            run_instr("alu", c);
            total += c;
        end
        checks++;
        if (total !== 12) begin
            errors++;
            $display("FAIL alu_cycles: got %0d expected 12", total);
        end
        checks++;
        if (pc !== 8'h0C) begin
            errors++;
            $display("FAIL alu_pc: got %h expected 0c", pc);
        end
    endtask

    task automatic test_load_store();
        int c;
        run_instr("sw_r3", c);
        checks++;
        if (c !== 4) begin
            errors++;
            $display("FAIL sw_cycles: got %0d expected 4", c);
        end
        checks++;
        if ({wcount, last_waddr, last_wdata} !== {32'd1, 8'h08, 32'd2}) begin
            errors++;
            $display("FAIL sw_r3_write: count %0d addr %h data %h expected 1 08 00000002",
                     wcount, last_waddr, last_wdata);
        end
        run_instr("lw_r4", c);
        checks++;
        if (c !== 5) begin
            errors++;
            $display("FAIL lw_cycles: got %0d expected 5", c);
        end
        run_instr("sw_r4", c);
        checks++;
        if ({wcount, last_waddr, last_wdata} !== {32'd2, 8'h0C, 32'd2}) begin
            errors++;
            $display("FAIL lw_r4_value: count %0d addr %h data %h expected 2 0c 00000002",
                     wcount, last_waddr, last_wdata);
        end
    endtask

    task automatic test_wait_states();
        int c;
        hold_reset();
        imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd7);
        imem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0020);
        imem[2] = BAD_OP;
        mem_ready = 1'b0;
        release_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({mem_req, mem_we, mem_addr, instr_done} !== {2'b10, 8'h00, 1'b0}) begin
                errors++;
                $display("FAIL fetch_wait_%0d: req %b we %b addr %h done %b expected 1 0 00 0",
                         i, mem_req, mem_we, mem_addr, instr_done);
            end
            step();
        end
        mem_ready = 1'b1;
        #1;
        run_instr("addi_wait", c);
        checks++;
        if (c + 3 !== 7) begin
            errors++;
            $display("FAIL fetch_wait_latency: got %0d expected 7", c + 3);
        end
        // sw with two wait cycles in MEM
        step();
        step();
        mem_ready = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, instr_done} !== {2'b11, 8'h20, 32'd7, 1'b0}) begin
                errors++;
                $display("FAIL mem_wait_%0d: req %b we %b addr %h data %h done %b expected 1 1 20 00000007 0",
                         i, mem_req, mem_we, mem_addr, mem_wdata, instr_done);
            end
            if (i == 0) step();
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (instr_done !== 1'b1) begin
            errors++;
            $display("FAIL mem_wait_retire: got %b expected 1", instr_done);
        end
        step();
        checks++;
        if ({wcount, last_waddr, last_wdata} !== {32'd1, 8'h20, 32'd7}) begin
            errors++;
            $display("FAIL mem_wait_write: count %0d addr %h data %h expected 1 20 00000007",
                     wcount, last_waddr, last_wdata);
        end
    endtask

    task automatic test_branch();
        int c;
        int exp_cyc [7] = '{4, 4, 3, 3, 3, 4, 3};
        logic [7:0] exp_pc [7] = '{8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h10};
        hold_reset();
        imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        imem[2] = {6'h02, 26'd4};
        imem[3] = BAD_OP;
        imem[4] = enc_i(6'h04, 5'd1, 5'd2, 16'hFFFF);
        imem[5] = 32'd0;
        imem[6] = enc_i(6'h08, 5'd0, 5'd2, 16'd5);
        imem[7] = {6'h02, 26'd4};
        release_reset();
        // addi, addi, j 0x10, beq not taken, nop, addi r2=5, j 0x10
        for (int i = 0; i < 7; i++) begin
            run_instr("branch_seq", c);
            checks++;
            if ({c, pc} !== {exp_cyc[i], exp_pc[i]}) begin
                errors++;
                $display("FAIL branch_seq_%0d: cycles %0d pc %h expected %0d %h",
                         i, c, pc, exp_cyc[i], exp_pc[i]);
            end
        end
        // beq now taken onto itself
        for (int i = 0; i < 2; i++) begin
            run_instr("beq_taken", c);
            checks++;
            if ({c, pc, mem_addr} !== {32'd3, 8'h10, 8'h10}) begin
                errors++;
                $display("FAIL beq_taken_%0d: cycles %0d pc %h addr %h expected 3 10 10",
                         i, c, pc, mem_addr);
            end
        end
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL branch_illegal: got %b expected 0", illegal);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] prog [3] = '{BAD_OP, enc_i(6'h23, 5'd0, 5'd1, 16'd6), enc_r(5'd1, 5'd2, 5'd3, 6'h21)};
        int steps [3] = '{2, 3, 3};
        bool_check: for (int t = 0; t < 3; t++) begin
            hold_reset();
            imem[0] = prog[t];
            imem[1] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
            release_reset();
            for (int s = 0; s < steps[t]; s++) begin
                checks++;
                if (illegal !== 1'b0) begin
                    errors++;
                    $display("FAIL illegal_early_%0d_%0d: got %b expected 0", t, s, illegal);
                end
                step();
            end
            for (int s = 0; s < 4; s++) begin
                checks++;
                if ({state, illegal, mem_req, instr_done, pc} !== {3'd5, 3'b100, 8'h04}) begin
                    errors++;
                    $display("FAIL halt_%0d_%0d: state %0d ill %b req %b done %b pc %h expected 5 1 0 0 04",
                             t, s, state, illegal, mem_req, instr_done, pc);
                end
                step();
            end
        end
    endtask

    task automatic test_reset_mid();
        int c;
        hold_reset();
        imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        imem[2] = enc_r(5'd2, 5'd1, 5'd5, 6'h2A);
        imem[3] = enc_i(6'h2B, 5'd0, 5'd5, 16'h0040);
        imem[4] = enc_i(6'h23, 5'd0, 5'd6, 16'h0040);
        release_reset();
        for (int i = 0; i < 3; i++) run_instr("slt_prep", c);
        run_instr("sw_r5", c);
        checks++;
        if ({last_waddr, last_wdata} !== {8'h40, 32'd1}) begin
            errors++;
            $display("FAIL slt_value: addr %h data %h expected 40 00000001", last_waddr, last_wdata);
        end
        // lw stalls in MEM, then reset lands mid-cycle
        step();
        step();
        mem_ready = 1'b0;
        step();
        checks++;
        if ({mem_req, mem_we, mem_addr} !== {2'b10, 8'h40}) begin
            errors++;
            $display("FAIL lw_wait: req %b we %b addr %h expected 1 0 40", mem_req, mem_we, mem_addr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_we, instr_done, illegal, mem_addr, mem_wdata, pc, state} !== 55'd0) begin
            errors++;
            $display("FAIL reset_mid: req %b we %b done %b ill %b addr %h data %h pc %h state %0d expected all 0",
                     mem_req, mem_we, instr_done, illegal, mem_addr, mem_wdata, pc, state);
        end
        for (int i = 0; i < 64; i++) imem[i] = 32'd0;
        imem[0] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0048);
        imem[1] = enc_i(6'h2B, 5'd0, 5'd5, 16'h004C);
        imem[2] = enc_i(6'h2B, 5'd0, 5'd31, 16'h0050);
        imem[3] = BAD_OP;
        mem_ready = 1'b1;
        release_reset();
        for (int i = 0; i < 3; i++) begin
            run_instr("regs_cleared", c);
            checks++;
            if ({wcount, last_waddr, last_wdata} !== {i + 1, 8'h48 + 8'(4 * i), 32'd0}) begin
                errors++;
                $display("FAIL regs_cleared_%0d: count %0d addr %h data %h expected %0d %h 00000000",
                         i, wcount, last_waddr, last_wdata, i + 1, 8'h48 + 8'(4 * i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_wait_states();
        test_branch();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
